// File: rtl/multi_photon_counter.sv
// multi_photon_counter
//   Multi-channel gated photon counter. Counts rising edges on NCH
//   asynchronous detector inputs over a programmable window of g_clk
//   cycles, counts ch0/ch1 same-cycle coincidences, and publishes a latched
//   result set through a valid/ready handshake.
//
// Ports
//   g_clk        system clock
//   g_rst        asynchronous, active-high reset
//   g_ch         asynchronous detector pulses, one bit per channel
//   g_start      one-cycle pulse, begins gating when idle
//   g_stop       one-cycle pulse, aborts gating (wins over g_start)
//   g_continuous 1 = back-to-back windows, 0 = single shot
//   g_gate_len   window length in g_clk cycles (0 = do not start)
//   g_counts     latched per-channel counts, channel i at [i*COUNTSIZE +: COUNTSIZE]
//   g_coinc      latched ch0/ch1 coincidence count
//   g_valid      result set available
//   g_ready      consumer accepts the result when g_valid & g_ready
//   g_overrun    sticky: an unread result was overwritten
//   g_busy       high while counting
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no window open; waiting for g_start with a non-zero length
// S_COUNT | window open; accumulators update, gate counter runs down to 1
module multi_photon_counter #(
  parameter int NCH       = 4,
  parameter int COUNTSIZE = 32,
  parameter int GATEWIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                     g_clk,
  input  logic                     g_rst,
  input  logic [NCH-1:0]           g_ch,
  input  logic                     g_start,
  input  logic                     g_stop,
  input  logic                     g_continuous,
  input  logic [GATEWIDTH-1:0]     g_gate_len,
  output logic [NCH*COUNTSIZE-1:0] g_counts,
  output logic [COUNTSIZE-1:0]     g_coinc,
  output logic                     g_valid,
  input  logic                     g_ready,
  output logic                     g_overrun,
  output logic                     g_busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam logic [COUNTSIZE-1:0] CNT_ONE  = {{(COUNTSIZE-1){1'b0}}, 1'b1};
  localparam logic [GATEWIDTH-1:0] GATE_ONE = {{(GATEWIDTH-1){1'b0}}, 1'b1};
  localparam logic [GATEWIDTH-1:0] GATE_ZERO = '0;

  logic [NCH-1:0] sync1_q, sync2_q, edge_q;
  logic [NCH-1:0] pos_edge;

  logic [0:0]                         state_q, state_d;
  logic [GATEWIDTH-1:0]               gate_q, gate_d;
  logic [NCH-1:0][COUNTSIZE-1:0]      acc_q, acc_d, acc_inc;
  logic [COUNTSIZE-1:0]               cacc_q, cacc_d, cacc_inc;
  logic [NCH*COUNTSIZE-1:0]           counts_q, counts_d;
  logic [COUNTSIZE-1:0]               coinc_q, coinc_d;
  logic                               valid_q, valid_d;
  logic                               overrun_q, overrun_d;
  logic                               load;

  function automatic logic [COUNTSIZE-1:0] bump(input logic [COUNTSIZE-1:0] v);
    if ((SATURATE != 0) && (&v)) return v;
    return v + CNT_ONE;
  endfunction

  assign pos_edge = sync2_q & ~edge_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      acc_inc[i] = pos_edge[i] ? bump(acc_q[i]) : acc_q[i];
    end
    cacc_inc = (pos_edge[0] & pos_edge[1]) ? bump(cacc_q) : cacc_q;
  end

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    acc_d     = acc_q;
    cacc_d    = cacc_q;
    counts_d  = counts_q;
    coinc_d   = coinc_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (g_start && !g_stop && (g_gate_len != GATE_ZERO)) begin
          state_d   = S_COUNT;
          gate_d    = g_gate_len;
          acc_d     = '0;
          cacc_d    = '0;
          overrun_d = 1'b0;
        end
      end
      default: begin
        if (g_stop) begin
          state_d = S_IDLE;
          gate_d  = GATE_ZERO;
          acc_d   = '0;
          cacc_d  = '0;
        end else if (gate_q == GATE_ONE) begin
          // Last window edge: publish including this edge's increments.
          load   = 1'b1;
          acc_d  = '0;
          cacc_d = '0;
          if (g_continuous && (g_gate_len != GATE_ZERO)) begin
            gate_d = g_gate_len;
          end else begin
            state_d = S_IDLE;
            gate_d  = GATE_ZERO;
          end
        end else begin
          acc_d  = acc_inc;
          cacc_d = cacc_inc;
          gate_d = gate_q - GATE_ONE;
        end
      end
    endcase

    if (valid_q && g_ready) valid_d = 1'b0;

    if (load) begin
      counts_d = acc_inc;
      coinc_d  = cacc_inc;
      valid_d  = 1'b1;
      // Accept at the same edge hands the old result over cleanly.
      if (valid_q && !g_ready) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      edge_q    <= '0;
      state_q   <= S_IDLE;
      gate_q    <= '0;
      acc_q     <= '0;
      cacc_q    <= '0;
      counts_q  <= '0;
      coinc_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= g_ch;
      sync2_q   <= sync1_q;
      edge_q    <= sync2_q;
      state_q   <= state_d;
      gate_q    <= gate_d;
      acc_q     <= acc_d;
      cacc_q    <= cacc_d;
      counts_q  <= counts_d;
      coinc_q   <= coinc_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign g_counts  = counts_q;
  assign g_coinc   = coinc_q;
  assign g_valid   = valid_q;
  assign g_overrun = overrun_q;
  assign g_busy    = (state_q == S_COUNT);

endmodule

// File: tb/tb_multi_photon_counter.sv
// tb_multi_photon_counter
//   Directed-plus-random bench for multi_photon_counter. Three instances
//   share the stimulus: a 32-bit saturating counter, and two 4-bit counters
//   (saturating and wrapping). Expected results come from a list of pulse
//   events, each tagged with the clock edge at which it is due to count;
//   a window's result is the number of events whose edge lies inside it.
module tb_multi_photon_counter;

  logic         g_clk;
  logic         g_rst;
  logic [3:0]   g_ch;
  logic         g_start;
  logic         g_stop;
  logic         g_continuous;
  logic [31:0]  g_gate_len;
  logic         g_ready;

  logic [127:0] g_counts;
  logic [31:0]  g_coinc;
  logic         g_valid, g_overrun, g_busy;

  logic [15:0]  counts_s, counts_w;
  logic [3:0]   coinc_s, coinc_w;
  logic         valid_s, valid_w, overrun_s, overrun_w, busy_s, busy_w;

  multi_photon_counter #(.NCH(4), .COUNTSIZE(32), .GATEWIDTH(32), .SATURATE(1)) u_main (
    .g_clk(g_clk), .g_rst(g_rst), .g_ch(g_ch), .g_start(g_start), .g_stop(g_stop),
    .g_continuous(g_continuous), .g_gate_len(g_gate_len), .g_counts(g_counts),
    .g_coinc(g_coinc), .g_valid(g_valid), .g_ready(g_ready), .g_overrun(g_overrun),
    .g_busy(g_busy));

  multi_photon_counter #(.NCH(4), .COUNTSIZE(4), .GATEWIDTH(32), .SATURATE(1)) u_sat (
    .g_clk(g_clk), .g_rst(g_rst), .g_ch(g_ch), .g_start(g_start), .g_stop(g_stop),
    .g_continuous(g_continuous), .g_gate_len(g_gate_len), .g_counts(counts_s),
    .g_coinc(coinc_s), .g_valid(valid_s), .g_ready(g_ready), .g_overrun(overrun_s),
    .g_busy(busy_s));

  multi_photon_counter #(.NCH(4), .COUNTSIZE(4), .GATEWIDTH(32), .SATURATE(0)) u_wrap (
    .g_clk(g_clk), .g_rst(g_rst), .g_ch(g_ch), .g_start(g_start), .g_stop(g_stop),
    .g_continuous(g_continuous), .g_gate_len(g_gate_len), .g_counts(counts_w),
    .g_coinc(coinc_w), .g_valid(valid_w), .g_ready(g_ready), .g_overrun(overrun_w),
    .g_busy(busy_w));

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t0;
  int ev_edge[$];
  logic [3:0] ev_mask[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) step();
  endtask

  // Driven after edge c, sampled at c+1, counted at c+3.
  task automatic pulse(input logic [3:0] m);
    g_ch = m;
    ev_edge.push_back(cyc + 3);
    ev_mask.push_back(m);
    step();
    g_ch = 4'b0000;
    step();
  endtask

  task automatic gap(input int mx);
    repeat ($urandom_range(0, mx)) step();
  endtask

  task automatic start_win(input int len);
    g_gate_len = 32'(len);
    g_start    = 1'b1;
    t0         = cyc + 1;
    step();
    g_start    = 1'b0;
  endtask

  task automatic accept();
    g_ready = 1'b1;
    step();
    g_ready = 1'b0;
    chk("accept_valid", 128'(g_valid), 128'(0));
  endtask

  function automatic int cnt(input int ch, input int lo, input int hi);
    int n = 0;
    foreach (ev_edge[i])
      if (ev_mask[i][ch] && ev_edge[i] >= lo && ev_edge[i] <= hi) n++;
    return n;
  endfunction

  function automatic int ccnt(input int lo, input int hi);
    int n = 0;
    foreach (ev_edge[i])
      if (ev_mask[i][0] && ev_mask[i][1] && ev_edge[i] >= lo && ev_edge[i] <= hi) n++;
    return n;
  endfunction

  function automatic logic [127:0] exp_main(input int lo, input int hi);
    logic [127:0] e = '0;
    for (int ch = 0; ch < 4; ch++) e[ch*32 +: 32] = 32'(cnt(ch, lo, hi));
    return e;
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic chk_win(input string tag, input int lo, input int hi);
    logic [15:0] es, ew;
    int n;
    for (int ch = 0; ch < 4; ch++) begin
      n = cnt(ch, lo, hi);
      es[ch*4 +: 4] = 4'(sat15(n));
      ew[ch*4 +: 4] = 4'(n % 16);
    end
    n = ccnt(lo, hi);
    chk({tag, "_valid"},      128'(g_valid), 128'(1));
    chk({tag, "_counts"},     g_counts, exp_main(lo, hi));
    chk({tag, "_coinc"},      128'(g_coinc), 128'(n));
    chk({tag, "_sat_counts"}, 128'(counts_s), 128'(es));
    chk({tag, "_sat_coinc"},  128'(coinc_s), 128'(sat15(n)));
    chk({tag, "_wrap_counts"},128'(counts_w), 128'(ew));
    chk({tag, "_wrap_coinc"}, 128'(coinc_w), 128'(n % 16));
    chk({tag, "_small_valid"},128'({valid_s, valid_w}), 128'(2'b11));
  endtask

  initial begin
    int n0, n2, nc, nl;
    int plo, phi;
    g_rst = 1'b1; g_ch = '0; g_start = 1'b0; g_stop = 1'b0;
    g_continuous = 1'b0; g_gate_len = '0; g_ready = 1'b0;
    repeat (3) step();
    g_rst = 1'b0;
    step();

    // Reset state
    chk("rst_counts",  g_counts, 128'(0));
    chk("rst_coinc",   128'(g_coinc), 128'(0));
    chk("rst_flags",   128'({g_valid, g_overrun, g_busy}), 128'(0));
    chk("rst_small",   128'({counts_s, counts_w, valid_s, valid_w, overrun_s, overrun_w,
                             busy_s, busy_w}), 128'(0));

    // Single shot, L=100: 10 pulses on ch0, 3 on ch2, randomly interleaved
    start_win(100);
    chk("t1_busy", 128'(g_busy), 128'(1));
    n0 = 10; n2 = 3;
    while (n0 + n2 > 0) begin
      if (n2 == 0 || (n0 > 0 && $urandom_range(0, 1) == 0)) begin pulse(4'b0001); n0--; end
      else begin pulse(4'b0100); n2--; end
      gap(3);
    end
    wait_edge(t0 + 99);
    chk("t1_not_yet", 128'({g_valid, g_busy}), 128'(2'b01));
    step();
    chk_win("t1", t0 + 1, t0 + 100);
    chk("t1_const", g_counts, {32'd0, 32'd3, 32'd0, 32'd10});
    chk("t1_busy_after", 128'(g_busy), 128'(0));
    repeat (3) step();
    chk("t1_hold", 128'(g_valid), 128'(1));
    accept();

    // Coincidences: 5 joint ch0/ch1 pulses and 2 lone ch1 pulses
    start_win(100);
    nc = 5; nl = 2;
    while (nc + nl > 0) begin
      if (nl == 0 || (nc > 0 && $urandom_range(0, 1) == 0)) begin pulse(4'b0011); nc--; end
      else begin pulse(4'b0010); nl--; end
      gap(3);
    end
    wait_edge(t0 + 100);
    chk_win("coinc", t0 + 1, t0 + 100);
    chk("coinc_const", 128'({g_counts[63:0], g_coinc}), 128'({32'd7, 32'd5, 32'd5}));
    accept();

    // Boundary, single shot, L=4: ch0 counts at t+4, ch1 at t+5
    start_win(4);
    step();
    g_ch = 4'b0001; ev_edge.push_back(cyc + 3); ev_mask.push_back(4'b0001);
    step();
    g_ch = 4'b0010; ev_edge.push_back(cyc + 3); ev_mask.push_back(4'b0010);
    step();
    g_ch = 4'b0000;
    chk("bnd1_not_yet", 128'(g_valid), 128'(0));
    step();
    chk_win("bnd1", t0 + 1, t0 + 4);
    chk("bnd1_const", 128'(g_counts[63:0]), 128'({32'd0, 32'd1}));
    chk("bnd1_idle", 128'(g_busy), 128'(0));
    repeat (3) step();
    chk("bnd1_late_excluded", 128'(g_counts[63:0]), 128'({32'd0, 32'd1}));
    accept();

    // Boundary, continuous, L=4: the t+5 pulse lands in window 2
    g_continuous = 1'b1;
    start_win(4);
    step();
    g_ch = 4'b0001; ev_edge.push_back(cyc + 3); ev_mask.push_back(4'b0001);
    step();
    g_ch = 4'b0010; ev_edge.push_back(cyc + 3); ev_mask.push_back(4'b0010);
    step();
    g_ch = 4'b0000;
    step();
    chk_win("bnd2_w1", t0 + 1, t0 + 4);
    chk("bnd2_w1_busy", 128'(g_busy), 128'(1));
    g_continuous = 1'b0;
    accept();
    wait_edge(t0 + 7);
    chk("bnd2_w2_not_yet", 128'(g_valid), 128'(0));
    step();
    chk_win("bnd2_w2", t0 + 5, t0 + 8);
    chk("bnd2_w2_const", 128'(g_counts[63:0]), 128'({32'd1, 32'd0}));
    chk("bnd2_w2_flags", 128'({g_overrun, g_busy}), 128'(0));
    accept();

    // Saturation / wrap: 20 pulses on ch0
    start_win(100);
    repeat (20) begin pulse(4'b0001); gap(1); end
    wait_edge(t0 + 100);
    chk_win("sat", t0 + 1, t0 + 100);
    chk("sat_const", 128'({counts_s[3:0], counts_w[3:0], g_counts[31:0]}),
        128'({4'd15, 4'd4, 32'd20}));
    accept();

    // Continuous L=50, results left unread across two windows
    g_continuous = 1'b1;
    start_win(50);
    while (cyc + 6 < t0 + 50) begin pulse(4'($urandom_range(1, 15))); gap(3); end
    wait_edge(t0 + 50);
    chk_win("cont_w1", t0 + 1, t0 + 50);
    chk("cont_w1_ovr", 128'(g_overrun), 128'(0));
    g_continuous = 1'b0;
    while (cyc + 6 < t0 + 100) begin pulse(4'($urandom_range(1, 15))); gap(3); end
    wait_edge(t0 + 100);
    chk_win("cont_w2", t0 + 51, t0 + 100);
    chk("cont_w2_flags", 128'({g_overrun, overrun_s, overrun_w, g_busy}), 128'(4'b1110));
    plo = t0 + 51; phi = t0 + 100;
    accept();
    chk("cont_ovr_sticky", 128'(g_overrun), 128'(1));

    // Start in idle clears overrun; then stop mid-window
    start_win(10);
    chk("start_clears_ovr", 128'({g_overrun, g_busy}), 128'(2'b01));
    pulse(4'b0001);
    g_stop = 1'b1;
    step();
    g_stop = 1'b0;
    chk("stop_idle", 128'(g_busy), 128'(0));
    wait_edge(t0 + 14);
    chk("stop_no_valid", 128'(g_valid), 128'(0));
    chk("stop_results_kept", g_counts, exp_main(plo, phi));
    chk("stop_coinc_kept", 128'(g_coinc), 128'(ccnt(plo, phi)));

    // g_start with L=0 is ignored
    start_win(0);
    chk("len0_idle", 128'(g_busy), 128'(0));
    repeat (5) step();
    chk("len0_no_valid", 128'({g_valid, g_busy}), 128'(0));

    // Reset mid-window
    start_win(30);
    pulse(4'b0101);
    pulse(4'b0011);
    #2 g_rst = 1'b1;
    #3 g_rst = 1'b0;
    chk("rstmid_counts", g_counts, 128'(0));
    chk("rstmid_flags", 128'({g_coinc, g_valid, g_overrun, g_busy}), 128'(0));
    wait_edge(t0 + 35);
    chk("rstmid_no_valid", 128'({g_valid, g_busy, valid_s, valid_w}), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
